// File: rtl/csr_file_controller_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, sequencer states
// and address classification helpers.
package csr_file_controller_pkg;

  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // addr[11:10] == 2'b11 marks the read-only CSR space
  localparam logic [1:0] CSR_RO_BITS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } csr_state_t;

  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == CSR_RO_BITS;
  endfunction

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_file_controller_counter64.sv
// 64-bit counter with increment enable and independent 32-bit half writes;
// a write to either half replaces that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[31:0]  <= wdata;
      if (wr_hi) value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file_controller.sv
// Machine-mode CSR storage and IDLE/EXEC/DONE access sequencer with trap
// recording and mtvec/mepc export to fetch.
module csr_file_controller
  import csr_file_controller_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_req,
  output logic        csr_ready,
  input  logic [11:0] csr_addr,
  input  logic        csr_write_suppress,
  output logic [31:0] csr_rdata,
  input  logic [31:0] csr_wdata,
  output logic        csr_done,
  output logic        csr_illegal,
  input  logic        instret_pulse,
  input  logic        trap_valid,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_cause,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out
);

  csr_state_t  state, next_state;
  logic [11:0] addr_q;
  logic        suppress_q;
  logic        illegal_q;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle_raw, minstret_raw, mcycle, minstret;
  logic [31:0] read_val;
  logic        illegal_now;
  logic        accept;
  logic        commit;

  assign accept = csr_req && (state == ST_IDLE);
  // Read-only shadows never commit, even when the access itself is legal
  assign commit = (state == ST_EXEC) && !suppress_q && !illegal_q && !csr_is_ro(addr_q);

  assign mcycle   = COUNTERS_EN ? mcycle_raw   : 64'd0;
  assign minstret = COUNTERS_EN ? minstret_raw : 64'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (csr_req) next_state = ST_EXEC;
      ST_EXEC: next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign csr_ready   = (state == ST_IDLE);
  assign csr_done    = (state == ST_DONE);
  assign csr_illegal = (state == ST_DONE) && illegal_q;

  always_comb begin
    read_val = '0;
    case (csr_addr)
      CSR_MTVEC:                   read_val = mtvec;
      CSR_MSCRATCH:                read_val = mscratch;
      CSR_MEPC:                    read_val = mepc;
      CSR_MCAUSE:                  read_val = mcause;
      CSR_MCYCLE,   CSR_CYCLE:     read_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    read_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   read_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: read_val = minstret[63:32];
      default:                     read_val = '0;
    endcase
    illegal_now = !csr_is_implemented(csr_addr) || (csr_is_ro(csr_addr) && !csr_write_suppress);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      suppress_q <= 1'b0;
      illegal_q  <= 1'b0;
      csr_rdata  <= '0;
    end else if (accept) begin
      addr_q     <= csr_addr;
      suppress_q <= csr_write_suppress;
      illegal_q  <= illegal_now;
      csr_rdata  <= illegal_now ? 32'd0 : read_val;
    end
  end

  // A trap in the same cycle as a CSR write to mepc/mcause takes priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtvec    <= RESET_MTVEC;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (commit && addr_q == CSR_MTVEC)    mtvec    <= csr_wdata;
      if (commit && addr_q == CSR_MSCRATCH) mscratch <= csr_wdata;
      if (trap_valid) begin
        mepc   <= trap_epc & ~32'h3;
        mcause <= trap_cause;
      end else begin
        if (commit && addr_q == CSR_MEPC)   mepc   <= csr_wdata & ~32'h3;
        if (commit && addr_q == CSR_MCAUSE) mcause <= csr_wdata;
      end
    end
  end

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;

  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (COUNTERS_EN),
    .wr_lo (COUNTERS_EN && commit && addr_q == CSR_MCYCLE),
    .wr_hi (COUNTERS_EN && commit && addr_q == CSR_MCYCLEH),
    .wdata (csr_wdata),
    .value (mcycle_raw)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (COUNTERS_EN && instret_pulse),
    .wr_lo (COUNTERS_EN && commit && addr_q == CSR_MINSTRET),
    .wr_hi (COUNTERS_EN && commit && addr_q == CSR_MINSTRETH),
    .wdata (csr_wdata),
    .value (minstret_raw)
  );

endmodule

// File: tb/tb_csr_file_controller.sv
// Randomized self-checking bench for csr_file_controller against a
// transaction-level model of the CSR file.
module tb_csr_file_controller;

  logic        clk;
  logic        reset;
  logic        csr_req;
  logic        csr_ready;
  logic [11:0] csr_addr;
  logic        csr_write_suppress;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic        csr_done;
  logic        csr_illegal;
  logic        instret_pulse;
  logic        trap_valid;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;

  int n_checks = 0;
  int n_bad    = 0;
  bit rand_side = 1'b0;

  // model state
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;

  localparam logic [31:0] TB_RESET_MTVEC = 32'h0000_0100;

  csr_file_controller #(
    .RESET_MTVEC (TB_RESET_MTVEC),
    .COUNTERS_EN (1'b1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .csr_req            (csr_req),
    .csr_ready          (csr_ready),
    .csr_addr           (csr_addr),
    .csr_write_suppress (csr_write_suppress),
    .csr_rdata          (csr_rdata),
    .csr_wdata          (csr_wdata),
    .csr_done           (csr_done),
    .csr_illegal        (csr_illegal),
    .instret_pulse      (instret_pulse),
    .trap_valid         (trap_valid),
    .trap_epc           (trap_epc),
    .trap_cause         (trap_cause),
    .mtvec_out          (mtvec_out),
    .mepc_out           (mepc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mtvec    = TB_RESET_MTVEC;
    m_mscratch = '0;
    m_mepc     = '0;
    m_mcause   = '0;
    m_cycle    = '0;
    m_instret  = '0;
  endtask

  function automatic bit model_ro(input logic [11:0] a);
    return a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82;
  endfunction

  function automatic bit model_impl(input logic [11:0] a);
    return model_ro(a) || a == 12'h305 || a == 12'h340 || a == 12'h341 || a == 12'h342 ||
           a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h305:          return m_mtvec;
      12'h340:          return m_mscratch;
      12'h341:          return m_mepc;
      12'h342:          return m_mcause;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default:          return 32'd0;
    endcase
  endfunction

  // one clock: model sees the inputs present before the edge
  task automatic tick(input bit wr, input logic [11:0] wa, input logic [31:0] wd);
    bit          ip, tv;
    logic [31:0] epc, cause;
    ip = instret_pulse;
    tv = trap_valid;
    epc = trap_epc;
    cause = trap_cause;
    @(posedge clk);
    if (wr && wa == 12'hB00)      m_cycle = {m_cycle[63:32], wd};
    else if (wr && wa == 12'hB80) m_cycle = {wd, m_cycle[31:0]};
    else                          m_cycle = m_cycle + 64'd1;
    if (wr && wa == 12'hB02)      m_instret = {m_instret[63:32], wd};
    else if (wr && wa == 12'hB82) m_instret = {wd, m_instret[31:0]};
    else if (ip)                  m_instret = m_instret + 64'd1;
    if (wr && wa == 12'h305) m_mtvec    = wd;
    if (wr && wa == 12'h340) m_mscratch = wd;
    if (wr && wa == 12'h341) m_mepc     = {wd[31:2], 2'b00};
    if (wr && wa == 12'h342) m_mcause   = wd;
    if (tv) begin
      m_mepc   = {epc[31:2], 2'b00};
      m_mcause = cause;
    end
    @(negedge clk);
    instret_pulse = rand_side ? 1'($urandom_range(0, 1)) : 1'b0;
    trap_valid    = rand_side ? ($urandom_range(0, 7) == 0) : 1'b0;
    trap_epc      = $urandom;
    trap_cause    = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 12'h0, 32'h0);
  endtask

  // full accept/EXEC/DONE access, entered and left at a negedge in IDLE
  task automatic applyStimulus(input logic [11:0] addr, input bit sup, input logic [31:0] wdata,
                               input bit trap_en, input logic [31:0] t_epc, input logic [31:0] t_cause,
                               input bit hold_req);
    bit          legal, wr;
    logic [31:0] exp_rd;
    checkOutput("ready", csr_ready, 1);
    csr_req = 1'b1;
    csr_addr = addr;
    csr_write_suppress = sup;
    csr_wdata = $urandom;
    legal  = model_impl(addr) && !(model_ro(addr) && !sup);
    exp_rd = legal ? model_read(addr) : 32'd0;
    wr     = legal && !sup && !model_ro(addr);
    tick(1'b0, 12'h0, 32'h0);
    csr_req = hold_req;
    csr_addr = 12'($urandom);
    csr_wdata = wdata;
    if (trap_en) begin
      trap_valid = 1'b1;
      trap_epc = t_epc;
      trap_cause = t_cause;
    end
    checkOutput("exec_ready", csr_ready, 0);
    checkOutput("exec_done", csr_done, 0);
    checkOutput("exec_rdata", csr_rdata, exp_rd);
    tick(wr, addr, wdata);
    csr_req = 1'b0;
    csr_wdata = $urandom;
    checkOutput("done", csr_done, 1);
    checkOutput("illegal", csr_illegal, !legal);
    checkOutput("done_rdata", csr_rdata, exp_rd);
    checkOutput("mtvec_out", mtvec_out, m_mtvec);
    checkOutput("mepc_out", mepc_out, m_mepc);
    tick(1'b0, 12'h0, 32'h0);
    checkOutput("idle_done", csr_done, 0);
  endtask

  logic [11:0] addr_pool [16] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                                  12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                  12'h300, 12'h7C0, 12'hC01, 12'hB81};

  initial begin
    bit saw_done;
    reset = 1'b0;
    csr_req = 1'b0;
    csr_addr = '0;
    csr_write_suppress = 1'b0;
    csr_wdata = '0;
    instret_pulse = 1'b0;
    trap_valid = 1'b0;
    trap_epc = '0;
    trap_cause = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", csr_ready, 1);
    checkOutput("rst_done", csr_done, 0);
    checkOutput("rst_illegal", csr_illegal, 0);
    checkOutput("rst_rdata", csr_rdata, 0);
    checkOutput("rst_mtvec", mtvec_out, TB_RESET_MTVEC);
    checkOutput("rst_mepc", mepc_out, 0);
    reset = 1'b1;

    applyStimulus(12'h305, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    checkOutput("mtvec_read", csr_rdata, 32'h100);
    applyStimulus(12'h340, 1'b0, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0);
    checkOutput("mscratch_first", csr_rdata, 0);
    applyStimulus(12'h340, 1'b1, 32'h0, 1'b0, 0, 0, 1'b1);
    checkOutput("mscratch_second", csr_rdata, 32'hDEADBEEF);

    applyStimulus(12'hB00, 1'b0, 32'hFFFF_FFFE, 1'b0, 0, 0, 1'b0);
    idle(3);
    applyStimulus(12'hB00, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    applyStimulus(12'hB80, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    applyStimulus(12'hB80, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
    applyStimulus(12'hB00, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
    applyStimulus(12'hB80, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    checkOutput("wrap_hi", csr_rdata, 0);

    applyStimulus(12'hC00, 1'b0, 32'h1234_5678, 1'b0, 0, 0, 1'b0);
    applyStimulus(12'hC00, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);

    applyStimulus(12'h341, 1'b0, 32'h1234, 1'b1, 32'h0000_2003, 32'h0000_000B, 1'b0);
    checkOutput("trap_mepc", mepc_out, 32'h0000_2000);
    applyStimulus(12'h342, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    checkOutput("trap_mcause", csr_rdata, 32'hB);

    rand_side = 1'b1;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(addr_pool[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 4) == 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    rand_side = 1'b0;
    idle(1);

    // abort an mscratch write by resetting during EXEC
    csr_req = 1'b1;
    csr_addr = 12'h340;
    csr_write_suppress = 1'b0;
    tick(1'b0, 12'h0, 32'h0);
    csr_req = 1'b0;
    csr_wdata = 32'h5555_AAAA;
    #2 reset = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (csr_done) saw_done = 1'b1;
    end
    checkOutput("abort_done", saw_done, 0);
    reset = 1'b1;
    model_reset();
    checkOutput("abort_ready", csr_ready, 1);
    applyStimulus(12'h340, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);
    checkOutput("abort_mscratch", csr_rdata, 0);
    applyStimulus(12'hB00, 1'b1, 32'h0, 1'b0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
